axi_grid_sni: RTL and testbench

Slave-side network interface of the AXI grid. It sits directly upstream of axi_grid_mni. It accepts AXI requests from a local master, decodes the destination NI from the address, and injects AW/W/AR flits into the grid. It takes B/R flits addressed to its own NI back from the grid and returns them on the AXI response bus. The block tracks outstanding transactions per direction and enforces a same-destination ordering rule.

---
 rtl/axi_default_param_pkg.sv | 96 +++++++++
 rtl/axi_grid_fifo.sv | 59 +++++
 rtl/axi_grid_sni.sv | 181 ++++++++++++++++++
 tb/tb_axi_grid_sni.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_default_param_pkg.sv
// AXI request/response bundles and grid flit types shared by the AXI grid
// slave-side and master-side network interfaces.
package axi_default_param_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_ID_W   = 4;
    localparam int unsigned GRID_ID_W  = 2;

    typedef logic [GRID_ID_W-1:0] grid_id_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } axi_ax_chan_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0]   data;
        logic [AXI_DATA_W/8-1:0] strb;
        logic                    last;
    } axi_w_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        axi_resp_e           resp;
    } axi_b_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        axi_resp_e             resp;
        logic                  last;
    } axi_r_chan_t;

    typedef struct packed {
        axi_ax_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ax_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } sni_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        axi_b_chan_t b;
        logic        b_valid;
        logic        ar_ready;
        axi_r_chan_t r;
        logic        r_valid;
    } sni_resp_t;

    typedef struct packed {
        grid_id_t     src_id;
        grid_id_t     dst_id;
        axi_ax_chan_t payload;
    } grid_aw_chan_t;

    typedef struct packed {
        grid_id_t    src_id;
        grid_id_t    dst_id;
        axi_w_chan_t payload;
    } grid_w_chan_t;

    typedef struct packed {
        grid_id_t    src_id;
        grid_id_t    dst_id;
        axi_b_chan_t payload;
    } grid_b_chan_t;

    typedef struct packed {
        grid_id_t     src_id;
        grid_id_t     dst_id;
        axi_ax_chan_t payload;
    } grid_ar_chan_t;

    typedef struct packed {
        grid_id_t    src_id;
        grid_id_t    dst_id;
        axi_r_chan_t payload;
    } grid_r_chan_t;

endpackage

// File: rtl/axi_grid_fifo.sv
// Synchronous FIFO with a parameterised element type and depth.
// Push is ignored while full and pop is ignored while empty.
module axi_grid_fifo #(
    parameter type         elem_t = logic,
    parameter int unsigned DEPTH  = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  elem_t push_data,
    input  logic  pop,
    output elem_t head,
    output logic  full,
    output logic  empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    elem_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        full    = (count == CNT_W'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/axi_grid_sni.sv
// Slave-side grid network interface: turns local AXI requests into AW/W/AR grid
// flits and hands B/R flits addressed to this NI back to the local master.
module axi_grid_sni
    import axi_default_param_pkg::*;
#(
    parameter type         req_t          = sni_req_t,
    parameter type         resp_t         = sni_resp_t,
    parameter type         grid_id_t      = axi_default_param_pkg::grid_id_t,
    parameter type         grid_aw_chan_t = axi_default_param_pkg::grid_aw_chan_t,
    parameter type         grid_w_chan_t  = axi_default_param_pkg::grid_w_chan_t,
    parameter type         grid_b_chan_t  = axi_default_param_pkg::grid_b_chan_t,
    parameter type         grid_ar_chan_t = axi_default_param_pkg::grid_ar_chan_t,
    parameter type         grid_r_chan_t  = axi_default_param_pkg::grid_r_chan_t,
    parameter grid_id_t    NI_ID          = '0,
    parameter int unsigned NUM_NI         = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned MAX_OUTST      = 8
) (
    input  logic          clk_i,
    input  logic          arst_ni,
    input  req_t          req_i,
    output resp_t         resp_o,
    output grid_aw_chan_t grid_aw_o,
    output logic          grid_aw_valid_o,
    input  logic          grid_aw_ready_i,
    output grid_w_chan_t  grid_w_o,
    output logic          grid_w_valid_o,
    input  logic          grid_w_ready_i,
    output grid_ar_chan_t grid_ar_o,
    output logic          grid_ar_valid_o,
    input  logic          grid_ar_ready_i,
    input  grid_b_chan_t  grid_b_i,
    input  logic          grid_b_valid_i,
    output logic          grid_b_ready_o,
    input  grid_r_chan_t  grid_r_i,
    input  logic          grid_r_valid_i,
    output logic          grid_r_ready_o
);

    localparam int unsigned DST_W = $clog2(NUM_NI);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

    logic [DST_W-1:0] aw_dst, ar_dst, last_wr_dst, last_rd_dst, fifo_head;
    logic [CNT_W-1:0] wr_cnt, rd_cnt;
    logic             aw_vld, w_vld, ar_vld;
    grid_aw_chan_t    aw_q, aw_d;
    grid_w_chan_t     w_q, w_d;
    grid_ar_chan_t    ar_q, ar_d;
    logic             aw_ok, ar_ok;
    logic             aw_ready, w_ready, ar_ready;
    logic             aw_acc, w_acc, ar_acc;
    logic             b_hit, r_hit, b_drop, r_drop;
    logic             b_hs, r_last_hs;
    logic             fifo_full, fifo_empty;
    logic             unused;

    assign unused = ^{grid_b_i.src_id, grid_r_i.src_id};

    // Destination of every accepted AW, so each W burst follows its address.
    axi_grid_fifo #(
        .elem_t (logic [DST_W-1:0]),
        .DEPTH  (MAX_OUTST)
    ) w_dst_fifo (
        .clk       (clk_i),
        .rst_n     (arst_ni),
        .push      (aw_acc),
        .push_data (aw_dst),
        .pop       (w_acc && req_i.w.last),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        aw_dst = req_i.aw.addr[ADDR_W-1 -: DST_W];
        ar_dst = req_i.ar.addr[ADDR_W-1 -: DST_W];

        // Only one destination in flight per direction keeps responses in order.
        aw_ok = (wr_cnt < CNT_MAX) && !fifo_full &&
                ((wr_cnt == '0) || (aw_dst == last_wr_dst));
        ar_ok = (rd_cnt < CNT_MAX) &&
                ((rd_cnt == '0) || (ar_dst == last_rd_dst));

        aw_ready = arst_ni && (!aw_vld || grid_aw_ready_i) && aw_ok;
        w_ready  = arst_ni && (!w_vld  || grid_w_ready_i)  && !fifo_empty;
        ar_ready = arst_ni && (!ar_vld || grid_ar_ready_i) && ar_ok;

        aw_acc = req_i.aw_valid && aw_ready;
        w_acc  = req_i.w_valid  && w_ready;
        ar_acc = req_i.ar_valid && ar_ready;

        aw_d         = '0;
        aw_d.src_id  = NI_ID;
        aw_d.dst_id  = grid_id_t'(aw_dst);
        aw_d.payload = req_i.aw;
        w_d          = '0;
        w_d.src_id   = NI_ID;
        w_d.dst_id   = grid_id_t'(fifo_head);
        w_d.payload  = req_i.w;
        ar_d         = '0;
        ar_d.src_id  = NI_ID;
        ar_d.dst_id  = grid_id_t'(ar_dst);
        ar_d.payload = req_i.ar;

        b_hit  = (grid_b_i.dst_id == NI_ID);
        r_hit  = (grid_r_i.dst_id == NI_ID);
        b_drop = grid_b_valid_i && !b_hit;
        r_drop = grid_r_valid_i && !r_hit;

        resp_o          = '0;
        resp_o.aw_ready = aw_ready;
        resp_o.w_ready  = w_ready;
        resp_o.ar_ready = ar_ready;
        resp_o.b        = grid_b_i.payload;
        resp_o.b_valid  = arst_ni && grid_b_valid_i && b_hit;
        resp_o.r        = grid_r_i.payload;
        resp_o.r_valid  = arst_ni && grid_r_valid_i && r_hit;

        // Misrouted flits are swallowed rather than left to block the grid.
        grid_b_ready_o = arst_ni && (b_hit ? req_i.b_ready : 1'b1);
        grid_r_ready_o = arst_ni && (r_hit ? req_i.r_ready : 1'b1);

        b_hs      = resp_o.b_valid && req_i.b_ready;
        r_last_hs = resp_o.r_valid && req_i.r_ready && grid_r_i.payload.last;
    end

    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            aw_vld      <= 1'b0;
            w_vld       <= 1'b0;
            ar_vld      <= 1'b0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            last_wr_dst <= '0;
            last_rd_dst <= '0;
        end else begin
            if (aw_acc)               aw_vld <= 1'b1;
            else if (grid_aw_ready_i) aw_vld <= 1'b0;
            if (w_acc)                w_vld  <= 1'b1;
            else if (grid_w_ready_i)  w_vld  <= 1'b0;
            if (ar_acc)               ar_vld <= 1'b1;
            else if (grid_ar_ready_i) ar_vld <= 1'b0;

            if (aw_acc) last_wr_dst <= aw_dst;
            if (ar_acc) last_rd_dst <= ar_dst;

            case ({aw_acc, b_hs})
                2'b10:   wr_cnt <= wr_cnt + CNT_W'(1);
                2'b01:   wr_cnt <= wr_cnt - CNT_W'(1);
                default: wr_cnt <= wr_cnt;
            endcase
            case ({ar_acc, r_last_hs})
                2'b10:   rd_cnt <= rd_cnt + CNT_W'(1);
                2'b01:   rd_cnt <= rd_cnt - CNT_W'(1);
                default: rd_cnt <= rd_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (aw_acc) aw_q <= aw_d;
        if (w_acc)  w_q  <= w_d;
        if (ar_acc) ar_q <= ar_d;
    end

    always_comb begin
        grid_aw_o       = aw_q;
        grid_aw_valid_o = aw_vld;
        grid_w_o        = w_q;
        grid_w_valid_o  = w_vld;
        grid_ar_o       = ar_q;
        grid_ar_valid_o = ar_vld;
    end

    b_route: assert property (@(posedge clk_i) disable iff (!arst_ni) !b_drop)
        else $warning("axi_grid_sni: dropped B flit addressed to NI %0d", grid_b_i.dst_id);
    r_route: assert property (@(posedge clk_i) disable iff (!arst_ni) !r_drop)
        else $warning("axi_grid_sni: dropped R flit addressed to NI %0d", grid_r_i.dst_id);

endmodule

// File: tb/tb_axi_grid_sni.sv
// Directed bench for axi_grid_sni: write/read paths, W-before-AW stall,
// outstanding limits, same-destination ordering, backpressure and misrouting.
module tb_axi_grid_sni;
    import axi_default_param_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    sni_req_t      req;
    sni_resp_t     resp;
    grid_aw_chan_t g_aw;
    logic          g_aw_valid, g_aw_ready;
    grid_w_chan_t  g_w;
    logic          g_w_valid, g_w_ready;
    grid_ar_chan_t g_ar;
    logic          g_ar_valid, g_ar_ready;
    grid_b_chan_t  g_b;
    logic          g_b_valid, g_b_ready;
    grid_r_chan_t  g_r;
    logic          g_r_valid, g_r_ready;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    axi_grid_sni #(
        .NI_ID     (2'd0),
        .NUM_NI    (4),
        .ADDR_W    (32),
        .MAX_OUTST (8)
    ) dut (
        .clk_i           (clk),
        .arst_ni         (rst_n),
        .req_i           (req),
        .resp_o          (resp),
        .grid_aw_o       (g_aw),
        .grid_aw_valid_o (g_aw_valid),
        .grid_aw_ready_i (g_aw_ready),
        .grid_w_o        (g_w),
        .grid_w_valid_o  (g_w_valid),
        .grid_w_ready_i  (g_w_ready),
        .grid_ar_o       (g_ar),
        .grid_ar_valid_o (g_ar_valid),
        .grid_ar_ready_i (g_ar_ready),
        .grid_b_i        (g_b),
        .grid_b_valid_i  (g_b_valid),
        .grid_b_ready_o  (g_b_ready),
        .grid_r_i        (g_r),
        .grid_r_valid_i  (g_r_valid),
        .grid_r_ready_o  (g_r_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic b_return(input logic [3:0] id);
        @(negedge clk);
        g_b = '0;
        g_b.dst_id = 2'd0;
        g_b.payload.id = id;
        g_b_valid = 1'b1;
        req.b_ready = 1'b1;
        #1;
        check("b_ret_valid", resp.b_valid, 1);
        check("b_ret_id", resp.b.id, id);
        @(negedge clk);
        g_b_valid = 1'b0;
        req.b_ready = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [1:0] dst);
        @(negedge clk);
        req.w_valid = 1'b1;
        req.w.data = data;
        req.w.strb = 4'hF;
        req.w.last = 1'b1;
        #1;
        check("w_beat_ready", resp.w_ready, 1);
        @(negedge clk);
        req.w_valid = 1'b0;
        #1;
        check("w_beat_valid", g_w_valid, 1);
        check("w_beat_dst", g_w.dst_id, dst);
        check("w_beat_data", g_w.payload.data, data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req = '0;
        g_b = '0;
        g_r = '0;
        g_b_valid = 1'b0;
        g_r_valid = 1'b0;
        g_aw_ready = 1'b1;
        g_w_ready = 1'b1;
        g_ar_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_aw_valid", g_aw_valid, 0);
        check("rst_w_valid", g_w_valid, 0);
        check("rst_ar_valid", g_ar_valid, 0);
        check("rst_aw_ready", resp.aw_ready, 0);
        check("rst_wr_cnt", dut.wr_cnt, 0);
        check("rst_rd_cnt", dut.rd_cnt, 0);
        rst_n = 1'b1;

        // 1: single write to dst 2
        @(negedge clk);
        req.aw_valid = 1'b1;
        req.aw.addr = 32'h8000_0000;
        req.aw.id = 4'd3;
        req.aw.len = 8'd0;
        req.w_valid = 1'b1;
        req.w.data = 32'hCAFE_0001;
        req.w.strb = 4'hF;
        req.w.last = 1'b1;
        #1;
        check("t1_aw_ready", resp.aw_ready, 1);
        check("t1_w_ready_early", resp.w_ready, 0);
        @(negedge clk);
        req.aw_valid = 1'b0;
        #1;
        check("t1_aw_valid", g_aw_valid, 1);
        check("t1_aw_dst", g_aw.dst_id, 2);
        check("t1_aw_src", g_aw.src_id, 0);
        check("t1_aw_addr", g_aw.payload.addr, 32'h8000_0000);
        check("t1_w_ready", resp.w_ready, 1);
        @(negedge clk);
        req.w_valid = 1'b0;
        #1;
        check("t1_aw_drained", g_aw_valid, 0);
        check("t1_w_valid", g_w_valid, 1);
        check("t1_w_dst", g_w.dst_id, 2);
        check("t1_w_data", g_w.payload.data, 32'hCAFE_0001);
        check("t1_wr_cnt", dut.wr_cnt, 1);
        b_return(4'd3);
        #1;
        check("t1_wr_cnt_ret", dut.wr_cnt, 0);
        check("t1_w_drained", g_w_valid, 0);

        // 2: W three cycles ahead of AW
        @(negedge clk);
        req.w_valid = 1'b1;
        req.w.data = 32'h0000_1111;
        req.w.last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_w_stall", resp.w_ready, 0);
            @(negedge clk);
        end
        req.aw_valid = 1'b1;
        req.aw.addr = 32'h4000_0000;
        req.aw.id = 4'd5;
        #1;
        check("t2_aw_ready", resp.aw_ready, 1);
        check("t2_w_stall_aw", resp.w_ready, 0);
        @(negedge clk);
        req.aw_valid = 1'b0;
        #1;
        check("t2_aw_flit", g_aw_valid, 1);
        check("t2_aw_dst", g_aw.dst_id, 1);
        check("t2_w_no_flit", g_w_valid, 0);
        check("t2_w_ready", resp.w_ready, 1);
        @(negedge clk);
        req.w_valid = 1'b0;
        #1;
        check("t2_w_flit", g_w_valid, 1);
        check("t2_w_dst", g_w.dst_id, 1);
        check("t2_w_data", g_w.payload.data, 32'h0000_1111);
        b_return(4'd5);
        #1;
        check("t2_wr_cnt", dut.wr_cnt, 0);

        // 3: read outstanding limit
        @(negedge clk);
        req.ar_valid = 1'b1;
        req.ar.addr = 32'h4000_0010;
        req.ar.id = 4'd1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("t3_ar_ready", resp.ar_ready, 1);
            @(negedge clk);
        end
        #1;
        check("t3_rd_cnt_full", dut.rd_cnt, 8);
        check("t3_ar_block", resp.ar_ready, 0);
        check("t3_ar_dst", g_ar.dst_id, 1);
        g_r = '0;
        g_r.dst_id = 2'd0;
        g_r.payload.data = 32'h0BAD_F00D;
        g_r.payload.last = 1'b0;
        g_r_valid = 1'b1;
        req.r_ready = 1'b1;
        #1;
        check("t3_r_valid", resp.r_valid, 1);
        check("t3_r_data", resp.r.data, 32'h0BAD_F00D);
        @(negedge clk);
        g_r.payload.last = 1'b1;
        #1;
        check("t3_rd_cnt_nolast", dut.rd_cnt, 8);
        check("t3_ar_block2", resp.ar_ready, 0);
        @(negedge clk);
        g_r_valid = 1'b0;
        req.r_ready = 1'b0;
        #1;
        check("t3_rd_cnt_dec", dut.rd_cnt, 7);
        check("t3_ar_reopen", resp.ar_ready, 1);
        @(negedge clk);
        req.ar_valid = 1'b0;
        #1;
        check("t3_rd_cnt_9th", dut.rd_cnt, 8);
        g_r_valid = 1'b1;
        req.r_ready = 1'b1;
        repeat (8) @(negedge clk);
        g_r_valid = 1'b0;
        req.r_ready = 1'b0;
        #1;
        check("t3_rd_cnt_drain", dut.rd_cnt, 0);

        // 4: same-destination ordering
        @(negedge clk);
        req.aw_valid = 1'b1;
        req.aw.addr = 32'h4000_0000;
        req.aw.id = 4'd1;
        #1;
        check("t4_aw_first", resp.aw_ready, 1);
        @(negedge clk);
        req.aw.addr = 32'hC000_0000;
        #1;
        check("t4_wr_cnt1", dut.wr_cnt, 1);
        check("t4_aw_block", resp.aw_ready, 0);
        @(negedge clk);
        #1;
        check("t4_aw_block2", resp.aw_ready, 0);
        req.aw.addr = 32'h4000_0100;
        #1;
        check("t4_same_dst", resp.aw_ready, 1);
        @(negedge clk);
        req.aw.addr = 32'hC000_0000;
        #1;
        check("t4_wr_cnt2", dut.wr_cnt, 2);
        check("t4_aw_block3", resp.aw_ready, 0);
        b_return(4'd1);
        #1;
        check("t4_wr_cnt_b1", dut.wr_cnt, 1);
        check("t4_aw_block4", resp.aw_ready, 0);
        b_return(4'd1);
        #1;
        check("t4_wr_cnt_b2", dut.wr_cnt, 0);
        check("t4_aw_unblock", resp.aw_ready, 1);
        @(negedge clk);
        req.aw_valid = 1'b0;
        #1;
        check("t4_wr_cnt3", dut.wr_cnt, 1);
        check("t4_aw_dst3", g_aw.dst_id, 3);
        w_beat(32'hA000_0001, 2'd1);
        w_beat(32'hA000_0002, 2'd1);
        w_beat(32'hA000_0003, 2'd3);
        b_return(4'd1);
        #1;
        check("t4_wr_cnt_end", dut.wr_cnt, 0);

        // 5: AW accept and B handshake in the same cycle
        @(negedge clk);
        req.aw_valid = 1'b1;
        req.aw.addr = 32'h8000_0000;
        req.aw.id = 4'd2;
        repeat (3) @(negedge clk);
        #1;
        check("t5_wr_cnt3", dut.wr_cnt, 3);
        g_b = '0;
        g_b.dst_id = 2'd0;
        g_b.payload.id = 4'd2;
        g_b_valid = 1'b1;
        req.b_ready = 1'b1;
        #1;
        check("t5_aw_ready", resp.aw_ready, 1);
        check("t5_b_valid", resp.b_valid, 1);
        @(negedge clk);
        req.aw_valid = 1'b0;
        g_b_valid = 1'b0;
        req.b_ready = 1'b0;
        #1;
        check("t5_wr_cnt_same", dut.wr_cnt, 3);
        for (int i = 0; i < 4; i++) w_beat(32'hB000_0000 + 32'(i), 2'd2);
        for (int i = 0; i < 3; i++) b_return(4'd2);
        #1;
        check("t5_wr_cnt_end", dut.wr_cnt, 0);

        // 6: grid backpressure, then a misrouted B flit
        g_aw_ready = 1'b0;
        @(negedge clk);
        req.aw_valid = 1'b1;
        req.aw.addr = 32'h8000_0000;
        req.aw.id = 4'd6;
        #1;
        check("t6_aw_ready", resp.aw_ready, 1);
        @(negedge clk);
        req.aw.addr = 32'h8000_0040;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t6_hold_valid", g_aw_valid, 1);
            check("t6_hold_addr", g_aw.payload.addr, 32'h8000_0000);
            check("t6_no_second", resp.aw_ready, 0);
            @(negedge clk);
        end
        g_aw_ready = 1'b1;
        #1;
        check("t6_drain_ready", resp.aw_ready, 1);
        @(negedge clk);
        req.aw_valid = 1'b0;
        #1;
        check("t6_second_addr", g_aw.payload.addr, 32'h8000_0040);
        check("t6_wr_cnt", dut.wr_cnt, 2);
        @(negedge clk);
        g_b = '0;
        g_b.dst_id = 2'd1;
        g_b.payload.id = 4'd7;
        g_b_valid = 1'b1;
        req.b_ready = 1'b0;
        #1;
        check("t6_mis_b_valid", resp.b_valid, 0);
        check("t6_mis_ready", g_b_ready, 1);
        check("t6_mis_drop", dut.b_drop, 1);
        @(negedge clk);
        g_b_valid = 1'b0;
        #1;
        check("t6_mis_wr_cnt", dut.wr_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
